// File: rtl/fifo_packer_pkg.sv
// Shared types and default sizing for the FIFO symbol packer.
package fifo_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int SYM_W_DEF = 2;
    localparam int PACK_DEF  = 4;

endpackage

// File: rtl/fifo_packer.sv
// Pops symbols from a first-word-fall-through FIFO and packs PACK of them
// LSB-first into one output word; a flush pulse emits a partial word early.
module fifo_packer
    import fifo_packer_pkg::*;
#(
    parameter  int SYM_W = SYM_W_DEF,
    parameter  int PACK  = PACK_DEF,
    localparam int OUT_W = SYM_W * PACK,
    localparam int CNT_W = $clog2(PACK) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] io_din,
    input  logic             io_empty,
    output logic             io_pop,
    input  logic             io_flush,
    output logic [OUT_W-1:0] io_out_data,
    output logic [CNT_W-1:0] io_out_count,
    output logic             io_out_valid,
    input  logic             io_out_ready
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [OUT_W-1:0] data;

    assign io_pop       = (state == FILL) && !io_empty;
    assign cnt_nxt      = cnt + {{(CNT_W-1){1'b0}}, io_pop};
    assign io_out_valid = (state == HOLD);
    assign io_out_data  = data;
    assign io_out_count = (state == HOLD) ? cnt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            cnt   <= '0;
            data  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (io_pop) begin
                        for (int k = 0; k < PACK; k++) begin
                            if (cnt == CNT_W'(k))
                                data[k*SYM_W +: SYM_W] <= io_din;
                        end
                    end
                    cnt <= cnt_nxt;
                    // Flush only counts once the same-cycle pop is included,
                    // so an empty packer ignores it.
                    if (cnt_nxt == CNT_W'(PACK) || (io_flush && cnt_nxt != '0))
                        state <= HOLD;
                end
                HOLD: begin
                    if (io_out_ready) begin
                        state <= FILL;
                        cnt   <= '0;
                        data  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packer.sv
// Directed bench for fifo_packer: a queue models the FWFT FIFO feeding the packer.
module tb_fifo_packer;

    localparam int SYM_W = 2;
    localparam int PACK  = 4;
    localparam int OUT_W = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [SYM_W-1:0] io_din;
    logic             io_empty;
    logic             io_pop;
    logic             io_flush;
    logic [OUT_W-1:0] io_out_data;
    logic [CNT_W-1:0] io_out_count;
    logic             io_out_valid;
    logic             io_out_ready;

    int checks = 0;
    int errors = 0;

    logic [SYM_W-1:0] fq[$];
    logic             pop_q;

    always #5 clk = ~clk;

    fifo_packer #(.SYM_W(SYM_W), .PACK(PACK)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_din      (io_din),
        .io_empty    (io_empty),
        .io_pop      (io_pop),
        .io_flush    (io_flush),
        .io_out_data (io_out_data),
        .io_out_count(io_out_count),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready)
    );

    // Remember whether the packer consumed the FIFO head on this edge.
    always @(posedge clk) pop_q <= io_pop && reset;

    task automatic fifo_upd();
        io_empty = (fq.size() == 0);
        io_din   = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [SYM_W-1:0] s);
        fq.push_back(s);
        fifo_upd();
    endtask

    // Advance past the next rising edge; FIFO model retires the popped head.
    task automatic nxt();
        @(posedge clk);
        #1;
        if (pop_q && fq.size() != 0) void'(fq.pop_front());
        fifo_upd();
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        smp();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", io_out_valid); end
        checks++; if (io_out_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", io_out_count); end
        checks++; if (io_out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", io_out_data); end
        checks++; if (io_pop !== 1'b0) begin errors++; $display("FAIL rst_pop: got %b want 0", io_pop); end
        nxt();
        reset = 1'b1;
        smp();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid: got %b want 0", io_out_valid); end
    endtask

    task automatic test_basic();
        int first = -1;
        int nv = 0;
        logic [OUT_W-1:0] d = '0;
        logic [CNT_W-1:0] c = '0;
        nxt();
        io_out_ready = 1'b1;
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        smp();
        checks++; if (io_pop !== 1'b1) begin errors++; $display("FAIL basic_pop: got %b want 1", io_pop); end
        for (int i = 1; i <= 7; i++) begin
            nxt(); smp();
            if (io_out_valid === 1'b1) begin
                nv++;
                if (first < 0) begin first = i; d = io_out_data; c = io_out_count; end
            end
        end
        checks++; if (first != 4) begin errors++; $display("FAIL basic_latency: got cycle %0d want 4", first); end
        checks++; if (nv != 1) begin errors++; $display("FAIL basic_width: got %0d cycles want 1", nv); end
        checks++; if (d !== 8'hE4) begin errors++; $display("FAIL basic_data: got %h want e4", d); end
        checks++; if (c !== 3'd4) begin errors++; $display("FAIL basic_count: got %0d want 4", c); end
    endtask

    task automatic test_stall();
        nxt();
        io_out_ready = 1'b0;
        push(2'd1); push(2'd3); push(2'd0); push(2'd2); push(2'd2); push(2'd1);
        for (int i = 1; i <= 4; i++) begin nxt(); smp(); end
        checks++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h8D || io_out_count !== 3'd4) begin
            errors++; $display("FAIL stall_word: got v=%b d=%h c=%0d want v=1 d=8d c=4", io_out_valid, io_out_data, io_out_count); end
        for (int j = 0; j < 5; j++) begin
            nxt(); smp();
            checks++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h8D || io_out_count !== 3'd4) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b d=%h c=%0d want v=1 d=8d c=4", j, io_out_valid, io_out_data, io_out_count); end
            checks++; if (io_pop !== 1'b0) begin errors++; $display("FAIL stall_pop%0d: got %b want 0", j, io_pop); end
        end
        nxt();
        io_out_ready = 1'b1;
        smp();
        checks++; if (io_out_valid !== 1'b1 || io_pop !== 1'b0) begin
            errors++; $display("FAIL stall_accept_cycle: got v=%b pop=%b want v=1 pop=0", io_out_valid, io_pop); end
        nxt(); smp();
        checks++; if (io_out_valid !== 1'b0 || io_out_count !== 3'd0 || io_pop !== 1'b1) begin
            errors++; $display("FAIL stall_after_accept: got v=%b c=%0d pop=%b want v=0 c=0 pop=1", io_out_valid, io_out_count, io_pop); end
        nxt();
        nxt();
        io_flush = 1'b1;
        smp();
        nxt();
        io_flush = 1'b0;
        smp();
        checks++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h06 || io_out_count !== 3'd2) begin
            errors++; $display("FAIL stall_tail: got v=%b d=%h c=%0d want v=1 d=06 c=2", io_out_valid, io_out_data, io_out_count); end
        nxt(); smp();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL stall_tail_done: got %b want 0", io_out_valid); end
    endtask

    task automatic test_flush();
        bit got = 0;
        nxt();
        io_out_ready = 1'b1;
        push(2'd3); push(2'd2);
        nxt();
        nxt();
        io_flush = 1'b1;
        smp();
        checks++; if (io_pop !== 1'b0) begin errors++; $display("FAIL flush_empty_pop: got %b want 0", io_pop); end
        nxt();
        io_flush = 1'b0;
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        smp();
        checks++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h0B || io_out_count !== 3'd2) begin
            errors++; $display("FAIL flush_partial: got v=%b d=%h c=%0d want v=1 d=0b c=2", io_out_valid, io_out_data, io_out_count); end
        checks++; if (io_pop !== 1'b0) begin errors++; $display("FAIL flush_hold_pop: got %b want 0", io_pop); end
        nxt(); smp();
        for (int i = 0; i < 10 && !got; i++) begin
            nxt(); smp();
            if (io_out_valid === 1'b1) got = 1;
        end
        checks++; if (!got || io_out_data !== 8'h39 || io_out_count !== 3'd4) begin
            errors++; $display("FAIL flush_next_word: got seen=%0d d=%h c=%0d want seen=1 d=39 c=4", got, io_out_data, io_out_count); end
        nxt();
    endtask

    task automatic test_flush_corner();
        int nv = 0;
        logic [OUT_W-1:0] d = '0;
        logic [CNT_W-1:0] c = '0;
        nxt();
        io_out_ready = 1'b1;
        io_flush = 1'b1;
        nxt();
        io_flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            smp();
            if (io_out_valid === 1'b1) nv++;
            nxt();
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL corner_idle_flush: got %0d valid cycles want 0", nv); end
        push(2'd3); push(2'd3); push(2'd3); push(2'd3);
        nxt(); nxt(); nxt();
        io_flush = 1'b1;
        nxt();
        io_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (io_out_valid === 1'b1) begin nv++; d = io_out_data; c = io_out_count; end
            nxt();
        end
        checks++; if (nv != 1 || d !== 8'hFF || c !== 3'd4) begin
            errors++; $display("FAIL corner_flush_last_pop: got n=%0d d=%h c=%0d want n=1 d=ff c=4", nv, d, c); end
        push(2'd2);
        io_flush = 1'b1;
        nxt();
        io_flush = 1'b0;
        smp();
        checks++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h02 || io_out_count !== 3'd1) begin
            errors++; $display("FAIL corner_flush_first_pop: got v=%b d=%h c=%0d want v=1 d=02 c=1", io_out_valid, io_out_data, io_out_count); end
        nxt(); smp();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL corner_single_done: got %b want 0", io_out_valid); end
    endtask

    task automatic test_reset_hold();
        bit got = 0;
        nxt();
        io_out_ready = 1'b0;
        push(2'd1); push(2'd1); push(2'd1); push(2'd1);
        for (int i = 0; i < 4; i++) nxt();
        smp();
        checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL rhold_pre: got %b want 1", io_out_valid); end
        #1 reset = 1'b0;
        #1;
        checks++; if (io_out_valid !== 1'b0 || io_out_count !== 3'd0 || io_out_data !== 8'h00) begin
            errors++; $display("FAIL rhold_async: got v=%b c=%0d d=%h want v=0 c=0 d=00", io_out_valid, io_out_count, io_out_data); end
        nxt();
        reset = 1'b1;
        io_out_ready = 1'b1;
        smp();
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rhold_no_stale: got %b want 0", io_out_valid); end
        nxt();
        push(2'd2); push(2'd0); push(2'd0); push(2'd0);
        for (int i = 0; i < 10 && !got; i++) begin
            nxt(); smp();
            if (io_out_valid === 1'b1) got = 1;
        end
        checks++; if (!got || io_out_data !== 8'h02 || io_out_count !== 3'd4) begin
            errors++; $display("FAIL rhold_repack: got seen=%0d d=%h c=%0d want seen=1 d=02 c=4", got, io_out_data, io_out_count); end
        nxt();
    endtask

    task automatic test_random();
        logic [SYM_W-1:0] eq[$];
        logic [SYM_W-1:0] s, e;
        int sent = 0, words = 0, bad = 0, empty_pops = 0, cyc = 0;
        io_out_ready = 1'b1;
        while ((sent < 1000 || words < 250) && cyc < 6000) begin
            nxt();
            if (sent < 1000 && $urandom_range(1, 0) == 1) begin
                s = SYM_W'($urandom_range(3, 0));
                push(s);
                eq.push_back(s);
                sent++;
            end
            smp();
            cyc++;
            if (io_pop === 1'b1 && io_empty === 1'b1) empty_pops++;
            if (io_out_valid === 1'b1) begin
                words++;
                if (io_out_count !== 3'd4) bad++;
                for (int k = 0; k < PACK; k++) begin
                    if (eq.size() == 0) bad++;
                    else begin
                        e = eq.pop_front();
                        if (io_out_data[k*SYM_W +: SYM_W] !== e) bad++;
                    end
                end
            end
        end
        checks++; if (words != 250) begin errors++; $display("FAIL rand_words: got %0d want 250", words); end
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_order: got %0d bad symbols want 0", bad); end
        checks++; if (empty_pops != 0) begin errors++; $display("FAIL rand_empty_pop: got %0d want 0", empty_pops); end
        checks++; if (eq.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d left want 0", eq.size()); end
        nxt();
    endtask

    initial begin
        reset        = 1'b0;
        io_flush     = 1'b0;
        io_out_ready = 1'b0;
        io_empty     = 1'b1;
        io_din       = '0;
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_flush_corner();
        test_reset_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter SYM_W, default 2, width of one FIFO symbol.
REQ-002 Parameter PACK, default 4, symbols per output word; OUT_W = SYM_W*PACK (8 by default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 asserts; release synchronous to clk by the system).
REQ-005 io_din  input  SYM_W  FIFO head symbol, first-word-fall-through, valid when io_empty=0.
REQ-006 io_empty  input  1  FIFO empty flag.
REQ-007 io_pop  output  1  FIFO pop strobe; head consumed on the clk edge where io_pop=1.
REQ-008 io_flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 io_out_data  output  OUT_W  packed word.
REQ-010 io_out_count  output  clog2(PACK)+1  valid symbols in io_out_data (1..PACK).
REQ-011 io_out_valid  output  1  word available.
REQ-012 io_out_ready  input  1  downstream accepts word when io_out_valid=1.

Function
REQ-013 Two states: FILL (collecting symbols) and HOLD (word presented, waiting for acceptance).
REQ-014 io_pop = (state==FILL) & ~io_empty; combinational, never asserted in HOLD or while io_empty=1.
REQ-015 Symbols are packed LSB-first: the k-th popped symbol (k=0..PACK-1) lands in bits [k*SYM_W +: SYM_W].
REQ-016 Each pop increments fill count cnt by 1; cnt range 0..PACK.
REQ-017 When a pop brings cnt to PACK: transition FILL->HOLD; io_out_valid=1 on the next cycle (latency 1 from final pop edge).
REQ-018 io_flush=1 in FILL with cnt>0 (after including any same-cycle pop): transition to HOLD with the partial word; unfilled bits read as 0.
REQ-019 io_flush=1 in FILL with cnt=0 and no same-cycle pop: ignored, no state change.
REQ-020 io_flush coinciding with a pop: the popped symbol is included first, then flush applies; a pop that completes the word makes flush redundant (single word emitted).
REQ-021 io_flush in HOLD: ignored, not remembered.
REQ-022 io_out_valid = (state==HOLD); io_out_data and io_out_count stable while io_out_valid=1 and io_out_ready=0.
REQ-023 HOLD with io_out_ready=1: word consumed on that edge; next state FILL, cnt=0, data register cleared to 0.
REQ-024 No pop occurs in the acceptance cycle; the first pop of the next word is at the earliest the cycle after acceptance (max throughput PACK symbols per PACK+1 cycles).
REQ-025 io_out_count equals cnt while in HOLD; io_out_count = 0 in FILL.
REQ-026 io_din is sampled only on edges where io_pop=1; it is don't-care otherwise.

Reset
REQ-027 reset=0 asynchronously forces: state=FILL, cnt=0, data register=0, io_out_valid=0, io_out_count=0, io_pop=0 until io_empty permits after release.
REQ-028 Reset during HOLD discards the pending word; no partial word is emitted after release.

Structure
REQ-029 Shared package holds the state enum {FILL, HOLD} and constants SYM_W_DEF=2, PACK_DEF=4.
REQ-030 Single flat module; no sub-module is warranted (one FSM register, one counter, one OUT_W data register).

Verification
REQ-031 Push 0,1,2,3 into FIFO, out_ready=1 -> out_data=8'hE4, out_count=4, valid 1 cycle after 4th pop, exactly 1 cycle wide.
REQ-032 Word complete with out_ready=0 for 5 cycles -> valid held, data stable, io_pop=0 despite FIFO non-empty; accepted on ready edge.
REQ-033 Push 3,2 then flush pulse -> out_data=8'h0B, out_count=2; next word starts at bits [1:0].
REQ-034 Flush with FIFO empty and cnt=0 -> no valid ever asserted; flush same cycle as 4th pop -> exactly one word, count=4.
REQ-035 Assert reset=0 mid-HOLD -> valid drops immediately (asynchronously), count=0; after release next word packs from bit 0.
REQ-036 Random push pattern, always-ready sink over 1000 symbols -> output stream equals input stream in order, no pops on empty.
